// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with programmable almost-full/empty levels, occupancy count,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo_v2 #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_en,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       r_en,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             wr_ok, rd_ok;

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // A write into a full FIFO is still accepted when a read frees the slot on the same edge.
   assign rd_ok = r_en & ~empty;
   assign wr_ok = w_en & (~full | rd_ok);

   always_comb begin
      wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      dout_d = rd_ok ? mem_q[rd_ptr_q] : dout_q;
      ovf_d  = (ovf_q & ~clr_err) | (w_en & ~wr_ok);
      unf_d  = (unf_q & ~clr_err) | (r_en & empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= data_in;
   end

   // In FWFT mode dout_q keeps the last popped word, shown only while the FIFO is empty.
   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? dout_q : mem_q[rd_ptr_q];
      end else begin : g_std
         assign data_out = dout_q;
      end
   endgenerate

endmodule
